// File: rtl/udp_test_pkg.sv
// udp_test_pkg
//   Definitions shared by the UDP test-stream generator and checker:
//   default stream geometry, the receive-checker state set, and a
//   saturating 32-bit increment used by the frame counters.
package udp_test_pkg;

  localparam int unsigned UDP_DATA_W    = 32;
  localparam int unsigned UDP_FRAME_LEN = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DRAIN    = 2'd2
  } rx_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/udp_rate_meter.sv
// udp_rate_meter
//   Counts good-frame pulses over fixed windows of SYS_FREQ clock cycles and
//   latches the per-window total at the last cycle of each window.
// Ports
//   clk     in   1   system clock
//   rst     in   1   synchronous reset, active-high
//   i_good  in   1   one-cycle pulse per completed good frame
//   o_rate  out  32  good frames counted in the previous complete window
module udp_rate_meter #(
  parameter int unsigned SYS_FREQ = 125_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_good,
  output logic [31:0] o_rate
);

  localparam int unsigned   CW       = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SYS_FREQ - 1);

  logic [CW-1:0] r_cyc;
  logic [31:0]   r_win;
  logic [31:0]   r_rate;
  logic [31:0]   w_win_next;

  // A frame completing on the window's final cycle still belongs to it.
  assign w_win_next = r_win + {31'd0, i_good};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc  <= '0;
      r_win  <= '0;
      r_rate <= '0;
    end else if (r_cyc == CYC_LAST) begin
      r_cyc  <= '0;
      r_win  <= '0;
      r_rate <= w_win_next;
    end else begin
      r_cyc  <= r_cyc + CW'(1);
      r_win  <= w_win_next;
    end
  end

  assign o_rate = r_rate;

endmodule

// File: rtl/udp_rx_stream_checker.sv
// udp_rx_stream_checker
//   Consumes the UDP receive user stream and checks that every frame is
//   FRAME_LEN words carrying 0,1,..,FRAME_LEN-1 with last on the final word.
//   Counts good/bad frames, reports good frames per rate window, drives status
//   LEDs and throttles rd_ready with a rotating pattern for soak testing.
// Ports
//   clk         in   1       system clock
//   rst         in   1       synchronous reset, active-high
//   rd_data     in   DATA_W  received payload word
//   rd_valid    in   1       word valid
//   rd_last     in   1       final word of frame
//   rd_ready    out  1       checker accepts word (registered pattern bit)
//   frames_ok   out  32      correct frames, saturating
//   frames_bad  out  32      bad frames, saturating
//   frame_rate  out  32      good frames in the previous rate window
//   led_ok      out  1       toggles on every good frame
//   led_err     out  1       held high LED_HOLD cycles after the latest bad frame
module udp_rx_stream_checker
  import udp_test_pkg::*;
#(
  parameter int unsigned DATA_W    = UDP_DATA_W,
  parameter int unsigned FRAME_LEN = UDP_FRAME_LEN,
  parameter int unsigned SYS_FREQ  = 125_000_000,
  parameter logic [7:0]  RDY_PAT   = 8'hFF,
  parameter int unsigned LED_HOLD  = 12_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  input  logic              rd_last,
  output logic              rd_ready,
  output logic [31:0]       frames_ok,
  output logic [31:0]       frames_bad,
  output logic [31:0]       frame_rate,
  output logic              led_ok,
  output logic              led_err
);

  localparam int unsigned   EW          = $clog2(FRAME_LEN) + 1;
  localparam logic [EW-1:0] LAST_IDX    = EW'(FRAME_LEN - 1);
  localparam int unsigned   HW          = $clog2(LED_HOLD + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(LED_HOLD - 1);

  rx_state_t   r_state;
  logic [EW-1:0] r_exp;
  logic [7:0]  r_pat;
  logic        r_rdy;
  logic [31:0] r_ok;
  logic [31:0] r_bad;
  logic        r_led_ok;
  logic        r_led_err;
  logic [HW-1:0] r_hold;

  logic              w_beat;
  logic [DATA_W-1:0] w_exp_ext;
  logic              w_at_end;
  logic              w_word_ok;
  logic              w_checking;
  logic              w_good;
  logic              w_bad;

  assign w_beat     = rd_valid & r_rdy;
  assign w_exp_ext  = DATA_W'(r_exp);
  assign w_at_end   = (r_exp == LAST_IDX);
  // One rule covers mismatch, early last and oversize: the word must match
  // and last must be present exactly at the final index.
  assign w_word_ok  = (rd_data == w_exp_ext) && (rd_last == w_at_end);
  assign w_checking = (r_state != DRAIN);
  assign w_good     = w_beat & w_checking & w_word_ok & rd_last;
  assign w_bad      = w_beat & w_checking & ~w_word_ok;

  // rd_ready comes straight from a register, so it never depends on rd_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= RDY_PAT;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= r_pat[0];
      r_pat <= {r_pat[0], r_pat[7:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_exp   <= '0;
    end else if (w_beat) begin
      if (rd_last) begin
        r_state <= IDLE;
        r_exp   <= '0;
      end else if (w_checking && w_word_ok) begin
        r_state <= IN_FRAME;
        r_exp   <= r_exp + EW'(1);
      end else begin
        r_state <= DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ok      <= '0;
      r_bad     <= '0;
      r_led_ok  <= 1'b0;
      r_led_err <= 1'b0;
      r_hold    <= '0;
    end else begin
      if (w_good) begin
        r_ok     <= sat_inc32(r_ok);
        r_led_ok <= ~r_led_ok;
      end
      if (w_bad) begin
        r_bad     <= sat_inc32(r_bad);
        r_led_err <= 1'b1;
        r_hold    <= HOLD_RELOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HW'(1);
      end else begin
        r_led_err <= 1'b0;
      end
    end
  end

  udp_rate_meter #(
    .SYS_FREQ (SYS_FREQ)
  ) u_rate (
    .clk    (clk),
    .rst    (rst),
    .i_good (w_good),
    .o_rate (frame_rate)
  );

  assign rd_ready   = r_rdy;
  assign frames_ok  = r_ok;
  assign frames_bad = r_bad;
  assign led_ok     = r_led_ok;
  assign led_err    = r_led_err;

endmodule
